nand_gate_unit: RTL and testbench



---
 rtl/nand_gate_unit.sv | 61 ++++++
 tb/tb_nand_gate_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/nand_gate_unit.sv
// nand_gate_unit: bitwise 2-input NAND with a combinational output, a
// registered copy qualified by a one-cycle valid pulse, and saturating
// activity counters (accepted samples and result toggles).
module nand_gate_unit #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             in_valid,
    output logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] y_q,
    output logic             y_q_valid,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] toggle_cnt
);

    // Degenerate widths make no sense for a gate or a counter.
    if (WIDTH < 1 || CNT_W < 1) begin : g_param_check
        $error("nand_gate_unit: WIDTH and CNT_W must both be >= 1");
    end

    // Increment that sticks at the all-ones maximum instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // ---- stage p0: combinational NAND and its qualifier ----
    logic [WIDTH-1:0] y_p0;
    logic             vld_p0;
    logic             diff_p0;

    assign y_p0    = ~(A & B);
    assign vld_p0  = in_valid;
    assign diff_p0 = (y_p0 != y_q);
    assign Y       = y_p0;

    // ---- stage p1: registered result, valid pulse and activity counters ----
    // Reset value of y_q is the NAND of all-zero operands, so the first
    // accepted sample's toggle test compares against all ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q        <= '1;
            y_q_valid  <= 1'b0;
            sample_cnt <= '0;
            toggle_cnt <= '0;
        end else begin
            y_q_valid <= vld_p0;
            if (vld_p0) begin
                y_q        <= y_p0;
                sample_cnt <= sat_inc(sample_cnt);
                if (diff_p0) begin
                    toggle_cnt <= sat_inc(toggle_cnt);
                end
            end
        end
    end

endmodule

// File: tb/tb_nand_gate_unit.sv
// Scoreboard bench for nand_gate_unit: two instances (4-bit / 3-bit counters
// and 1-bit / 2-bit counters) share clock, reset and in_valid.
module tb_nand_gate_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic [0:0] a1 = '0, b1 = '0;

    logic [3:0] y4, yq4;
    logic       yv4;
    logic [2:0] sc4, tc4;
    logic [0:0] y1, yq1;
    logic       yv1;
    logic [1:0] sc1, tc1;

    int checks = 0;
    int errors = 0;

    nand_gate_unit #(.WIDTH(4), .CNT_W(3)) dut_a (
        .clk(clk), .rst(rst), .A(a4), .B(b4), .in_valid(in_valid),
        .Y(y4), .y_q(yq4), .y_q_valid(yv4), .sample_cnt(sc4), .toggle_cnt(tc4)
    );

    nand_gate_unit #(.WIDTH(1), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .A(a1), .B(b1), .in_valid(in_valid),
        .Y(y1), .y_q(yq1), .y_q_valid(yv1), .sample_cnt(sc1), .toggle_cnt(tc1)
    );

    always #5 clk = ~clk;

    typedef struct {
        int y4; int sc4; int tc4;
        int y1; int sc1; int tc1;
    } exp_t;

    exp_t sbq[$];
    exp_t last;     // most recently presented expectation (held outputs)
    exp_t model;    // running reference state at stimulus time

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-bit NAND from the truth table: a bit is 0 only when both inputs are 1.
    function automatic int nand_ref(input int a, input int b, input int w);
        int r = 0;
        for (int i = 0; i < w; i++) begin
            if (!(((a >> i) & 1) == 1 && ((b >> i) & 1) == 1)) r += (1 << i);
        end
        return r;
    endfunction

    function automatic int sat_add(input int v, input int maxv);
        return (v >= maxv) ? maxv : v + 1;
    endfunction

    function automatic exp_t reset_state();
        exp_t e;
        e.y4 = 15; e.sc4 = 0; e.tc4 = 0;
        e.y1 = 1;  e.sc1 = 0; e.tc1 = 0;
        return e;
    endfunction

    task automatic check_comb();
        chk("Y4_comb", int'(y4), nand_ref(int'(a4), int'(b4), 4));
        chk("Y1_comb", int'(y1), nand_ref(int'(a1), int'(b1), 1));
    endtask

    // Drive one cycle of stimulus just after a rising edge; on acceptance the
    // reference state advances and the expected response is queued.
    task automatic step(input logic [3:0] a, input logic [3:0] b, input logic v);
        int n4, n1;
        @(posedge clk);
        #1;
        a4 = a; b4 = b; a1 = a[0]; b1 = b[0]; in_valid = v;
        #1;
        check_comb();
        if (v && !rst) begin
            n4 = nand_ref(int'(a), int'(b), 4);
            n1 = nand_ref(int'(a[0]), int'(b[0]), 1);
            if (n4 != model.y4) model.tc4 = sat_add(model.tc4, 7);
            if (n1 != model.y1) model.tc1 = sat_add(model.tc1, 3);
            model.sc4 = sat_add(model.sc4, 7);
            model.sc1 = sat_add(model.sc1, 3);
            model.y4 = n4;
            model.y1 = n1;
            sbq.push_back(model);
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_yq4"}, int'(yq4), 15);
        chk({tag, "_yv4"}, int'(yv4), 0);
        chk({tag, "_sc4"}, int'(sc4), 0);
        chk({tag, "_tc4"}, int'(tc4), 0);
        chk({tag, "_yq1"}, int'(yq1), 1);
        chk({tag, "_yv1"}, int'(yv1), 0);
        chk({tag, "_sc1"}, int'(sc1), 0);
        chk({tag, "_tc1"}, int'(tc1), 0);
    endtask

    // Monitor: pop an expectation whenever the registered path presents a
    // result; otherwise the outputs must hold the last presented values.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (yv4) begin
                chk("sb_nonempty", int'(sbq.size() > 0), 1);
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    last = e;
                end
            end
            chk("yv1_track", int'(yv1), int'(yv4));
            chk("yq4", int'(yq4), last.y4);
            chk("sc4", int'(sc4), last.sc4);
            chk("tc4", int'(tc4), last.tc4);
            chk("yq1", int'(yq1), last.y1);
            chk("sc1", int'(sc1), last.sc1);
            chk("tc1", int'(tc1), last.tc1);
        end
    end

    initial begin
        last  = reset_state();
        model = reset_state();

        // Reset held; registered outputs at reset values.
        #1 rst = 1'b1;
        #1 check_reset_values("reset");

        // Truth table, independent of clock and reset.
        for (int i = 0; i < 4; i++) begin
            a1 = 1'(i >> 1); b1 = 1'(i & 1);
            a4 = {4{a1}};    b4 = {4{b1}};
            #1 check_comb();
            #9;
        end

        // Release reset just after an edge.
        @(posedge clk);
        #1 rst = 1'b0;

        // Repeated 0,0: y_q stays all ones, no toggles.
        repeat (4) step(4'h0, 4'h0, 1'b1);
        step(4'h0, 4'h0, 1'b0);

        // Registered path with distinct patterns, then hold.
        step(4'hF, 4'hA, 1'b1);
        step(4'h3, 4'h5, 1'b1);
        step(4'h3, 4'h5, 1'b0);
        step(4'h0, 4'h0, 1'b0);

        // Alternating all-ones / all-zeros drives both counters to saturation.
        for (int i = 0; i < 6; i++) begin
            step((i % 2 == 0) ? 4'hF : 4'h0, (i % 2 == 0) ? 4'hF : 4'h0, 1'b1);
        end
        step(4'hF, 4'hF, 1'b1);
        step(4'h0, 4'h0, 1'b0);

        // Asynchronous reset between edges while in_valid is high.
        @(posedge clk);
        #1;
        a4 = 4'hC; b4 = 4'h6; a1 = 1'b1; b1 = 1'b1; in_valid = 1'b1;
        #2 rst = 1'b1;
        #1;
        sbq.delete();
        model = reset_state();
        last  = reset_state();
        check_reset_values("async_rst");
        check_comb();
        step(4'h0, 4'h0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Resume: 1,1 after reset yields a toggle from the all-ones value.
        step(4'h1, 4'h1, 1'b1);
        step(4'h0, 4'h0, 1'b0);

        // Randomized traffic with random gaps.
        for (int i = 0; i < 300; i++) begin
            step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 3) != 0));
        end

        // Drain: every queued expectation must have been presented.
        step(4'h0, 4'h0, 1'b0);
        step(4'h0, 4'h0, 1'b0);
        @(posedge clk);
        #2 chk("sb_drained", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
